// File: rtl/memtest_multi_wb.sv
// ============================================================================
// Module   : memtest_multi_wb
// Purpose  : Wishbone-controlled burst memory tester for the mi_* interface.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module memtest_multi_wb #(
    parameter int ADDR_WIDTH = 32,
    parameter int LEN_WIDTH  = 7,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [2:0]            wb_addr,
    input  logic [31:0]           wb_wdata,
    output logic [31:0]           wb_rdata,
    input  logic                  wb_we,
    input  logic                  wb_cyc,
    output logic                  wb_ack,
    output logic [ADDR_WIDTH-1:0] mi_addr,
    output logic [LEN_WIDTH-1:0]  mi_len,
    output logic                  mi_rw,
    output logic                  mi_valid,
    input  logic                  mi_ready,
    output logic [31:0]           mi_wdata,
    input  logic                  mi_wack,
    input  logic                  mi_wlast,
    input  logic [31:0]           mi_rdata,
    input  logic                  mi_rstb,
    input  logic                  mi_rlast
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_W_CMD  = 3'd1;
    localparam logic [2:0] S_W_DATA = 3'd2;
    localparam logic [2:0] S_R_CMD  = 3'd3;
    localparam logic [2:0] S_R_DATA = 3'd4;
    localparam logic [2:0] S_DONE   = 3'd5;

    logic [2:0]            r_state, w_state_nxt;
    logic                  r_ack;
    logic [31:0]           r_rdata;
    logic [ADDR_WIDTH-1:0] r_base, r_waddr;
    logic [CNT_WIDTH-1:0]  r_count, r_k;
    logic [LEN_WIDTH-1:0]  r_burst, r_widx;
    logic [31:0]           r_seed, r_lfsr;
    logic [31:0]           r_err_cnt, r_err_addr, r_err_data;
    logic [1:0]            r_mode, r_pat;
    logic                  r_busy, r_done, r_err, r_proto_err, r_abort;

    logic        w_wb_fire, w_wr, w_csr_wr, w_start, w_abort_wr, w_active, w_abort;
    logic        w_last_word, w_last_burst;
    logic        w_wstep, w_rstep, w_step, w_last_sig, w_mismatch;
    logic [31:0] w_seed_load, w_waddr32, w_pat_word, w_lfsr_nxt, w_rd_mux;

    assign w_wb_fire  = wb_cyc & ~r_ack;
    assign w_wr       = w_wb_fire & wb_we;
    assign w_csr_wr   = w_wr && (wb_addr == 3'd0);
    assign w_start    = w_csr_wr && wb_wdata[0] && !r_busy && (wb_wdata[3:2] != 2'd3);
    assign w_abort_wr = w_csr_wr && wb_wdata[1];
    assign w_active   = (r_state != S_IDLE) && (r_state != S_DONE);
    assign w_abort    = r_abort | (w_abort_wr & w_active);

    assign w_last_word  = (r_widx == r_burst);
    assign w_last_burst = (CNT_WIDTH'(r_k + 1'b1) == r_count);

    assign w_seed_load = (r_seed == 32'd0) ? 32'd1 : r_seed;
    assign w_waddr32   = 32'(r_waddr);
    assign w_lfsr_nxt  = {r_lfsr[30:0], r_lfsr[31] ^ r_lfsr[21] ^ r_lfsr[1] ^ r_lfsr[0]};

    always_comb begin
        w_pat_word = r_lfsr;
        case (r_pat)
            2'd0:    w_pat_word = r_lfsr;
            2'd1:    w_pat_word = w_waddr32;
            2'd2:    w_pat_word = r_seed;
            default: w_pat_word = ~w_waddr32;
        endcase
    end

    assign w_wstep    = (r_state == S_W_DATA) && mi_wack;
    assign w_rstep    = (r_state == S_R_DATA) && mi_rstb;
    assign w_step     = w_wstep | w_rstep;
    assign w_last_sig = w_wstep ? mi_wlast : mi_rlast;
    assign w_mismatch = w_rstep && (mi_rdata != w_pat_word);

    always_comb begin
        w_rd_mux = 32'd0;
        case (wb_addr)
            3'd0: w_rd_mux = {24'd0, r_pat, r_mode, r_proto_err, r_err, r_done, r_busy};
            3'd1: w_rd_mux = 32'(r_base);
            3'd2: w_rd_mux = 32'(r_count);
            3'd3: w_rd_mux = 32'(r_burst);
            3'd4: w_rd_mux = r_seed;
            3'd5: w_rd_mux = r_err_cnt;
            3'd6: w_rd_mux = r_err_addr;
            default: w_rd_mux = r_err_data;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_nxt;
    end

    // Bursts are terminated by the word counter; last-strobes only feed the protocol check.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (r_busy) begin
                    if (r_count == '0)       w_state_nxt = S_DONE;
                    else if (r_mode == 2'd1) w_state_nxt = S_R_CMD;
                    else                     w_state_nxt = S_W_CMD;
                end
            end
            S_W_CMD: begin
                if (mi_ready)     w_state_nxt = S_W_DATA;
                else if (w_abort) w_state_nxt = S_IDLE;
            end
            S_W_DATA: begin
                if (w_wstep && w_last_word) begin
                    if (w_abort)              w_state_nxt = S_IDLE;
                    else if (!w_last_burst)   w_state_nxt = S_W_CMD;
                    else if (r_mode == 2'd2)  w_state_nxt = S_R_CMD;
                    else                      w_state_nxt = S_DONE;
                end
            end
            S_R_CMD: begin
                if (mi_ready)     w_state_nxt = S_R_DATA;
                else if (w_abort) w_state_nxt = S_IDLE;
            end
            S_R_DATA: begin
                if (w_rstep && w_last_word) begin
                    if (w_abort)            w_state_nxt = S_IDLE;
                    else if (!w_last_burst) w_state_nxt = S_R_CMD;
                    else                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        mi_valid = 1'b0;
        mi_rw    = 1'b0;
        mi_addr  = r_waddr;
        mi_len   = r_burst;
        mi_wdata = 32'd0;
        case (r_state)
            S_W_CMD:  mi_valid = 1'b1;
            S_W_DATA: mi_wdata = w_pat_word;
            S_R_CMD: begin
                mi_valid = 1'b1;
                mi_rw    = 1'b1;
            end
            S_R_DATA: mi_rw = 1'b1;
            default: ;
        endcase
    end

    assign wb_ack   = r_ack;
    assign wb_rdata = r_rdata;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ack       <= 1'b0;
            r_rdata     <= 32'd0;
            r_base      <= '0;
            r_waddr     <= '0;
            r_count     <= '0;
            r_k         <= '0;
            r_burst     <= '0;
            r_widx      <= '0;
            r_seed      <= 32'd0;
            r_lfsr      <= 32'd0;
            r_err_cnt   <= 32'd0;
            r_err_addr  <= 32'd0;
            r_err_data  <= 32'd0;
            r_mode      <= 2'd0;
            r_pat       <= 2'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
            r_proto_err <= 1'b0;
            r_abort     <= 1'b0;
        end else begin
            r_ack   <= w_wb_fire;
            r_rdata <= w_wb_fire ? w_rd_mux : 32'd0;

            if (w_wr && !r_busy) begin
                case (wb_addr)
                    3'd0: begin
                        r_mode <= wb_wdata[3:2];
                        r_pat  <= wb_wdata[5:4];
                    end
                    3'd1: r_base  <= ADDR_WIDTH'(wb_wdata);
                    3'd2: r_count <= CNT_WIDTH'(wb_wdata);
                    3'd3: r_burst <= wb_wdata[LEN_WIDTH-1:0];
                    3'd4: r_seed  <= wb_wdata;
                    default: ;
                endcase
            end

            if (w_step) begin
                r_lfsr  <= w_lfsr_nxt;
                r_waddr <= r_waddr + 1'b1;
                r_widx  <= w_last_word ? '0 : r_widx + 1'b1;
                if (w_last_word)               r_k         <= r_k + 1'b1;
                if (w_last_sig != w_last_word) r_proto_err <= 1'b1;
            end

            if (w_mismatch) begin
                r_err <= 1'b1;
                if (r_err_cnt != 32'hFFFF_FFFF) r_err_cnt <= r_err_cnt + 32'd1;
                if (!r_err) begin
                    r_err_addr <= w_waddr32;
                    r_err_data <= mi_rdata;
                end
            end

            // Write+verify: rewind the generator so the read pass expects the same words.
            if ((r_state == S_W_DATA) && (w_state_nxt == S_R_CMD) && w_last_burst) begin
                r_lfsr  <= w_seed_load;
                r_waddr <= r_base;
                r_k     <= '0;
            end

            if (w_abort_wr && w_active) r_abort <= 1'b1;

            if (w_state_nxt == S_DONE) begin
                r_busy <= 1'b0;
                r_done <= 1'b1;
            end
            if (w_active && (w_state_nxt == S_IDLE)) begin
                r_busy  <= 1'b0;
                r_abort <= 1'b0;
            end

            if (w_start) begin
                r_busy      <= 1'b1;
                r_done      <= 1'b0;
                r_err       <= 1'b0;
                r_proto_err <= 1'b0;
                r_err_cnt   <= 32'd0;
                r_err_addr  <= 32'd0;
                r_err_data  <= 32'd0;
                r_lfsr      <= w_seed_load;
                r_waddr     <= r_base;
                r_k         <= '0;
                r_widx      <= '0;
                r_abort     <= 1'b0;
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_memtest_multi_wb.sv
// ============================================================================
// Module   : tb_memtest_multi_wb
// Purpose  : Randomised bench with memory responder and behavioural run model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_memtest_multi_wb;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  wb_addr;
    logic [31:0] wb_wdata, wb_rdata;
    logic        wb_we, wb_cyc, wb_ack;
    logic [31:0] mi_addr;
    logic [6:0]  mi_len;
    logic        mi_rw, mi_valid, mi_ready;
    logic [31:0] mi_wdata, mi_rdata;
    logic        mi_wack, mi_wlast, mi_rstb, mi_rlast;

    memtest_multi_wb #(.ADDR_WIDTH(32), .LEN_WIDTH(7), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_addr(wb_addr), .wb_wdata(wb_wdata), .wb_rdata(wb_rdata),
        .wb_we(wb_we), .wb_cyc(wb_cyc), .wb_ack(wb_ack),
        .mi_addr(mi_addr), .mi_len(mi_len), .mi_rw(mi_rw),
        .mi_valid(mi_valid), .mi_ready(mi_ready), .mi_wdata(mi_wdata),
        .mi_wack(mi_wack), .mi_wlast(mi_wlast), .mi_rdata(mi_rdata),
        .mi_rstb(mi_rstb), .mi_rlast(mi_rlast)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // ---------------- memory responder ----------------
    logic [31:0] mem [logic [31:0]];
    bit          stall = 0;
    int          rlast_at = -1;
    bit          corrupt_en = 0;
    logic [31:0] corrupt_addr = 0;
    int          rd_strobes = 0;
    bit          rs_busy = 0;
    logic [31:0] rs_addr;
    logic [6:0]  rs_len;
    logic        rs_rw;
    int          rs_idx;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return a ^ 32'h5A5A_A5A5;
    endfunction

    initial begin
        logic [31:0] a;
        mi_ready = 0; mi_wack = 0; mi_wlast = 0; mi_rstb = 0; mi_rlast = 0; mi_rdata = 0;
        forever begin
            @(negedge clk);
            mi_ready = 0; mi_wack = 0; mi_wlast = 0; mi_rstb = 0; mi_rlast = 0; mi_rdata = 0;
            if (!rst_n) begin
                rs_busy = 0;
            end else if (rs_busy) begin
                if ($urandom_range(0, 2) != 0) begin
                    a = rs_addr + 32'(rs_idx);
                    if (!rs_rw) begin
                        mi_wack  = 1;
                        mi_wlast = (rs_idx == int'(rs_len));
                        mem[a]   = mi_wdata;
                    end else begin
                        mi_rstb  = 1;
                        mi_rlast = (rlast_at >= 0) ? (rs_idx == rlast_at) : (rs_idx == int'(rs_len));
                        mi_rdata = (corrupt_en && a == corrupt_addr) ? 32'hDEAD_BEEF : mem_rd(a);
                        rd_strobes++;
                    end
                    rs_idx++;
                    if (rs_idx > int'(rs_len)) rs_busy = 0;
                end
            end else if (mi_valid && !stall && $urandom_range(0, 2) == 0) begin
                mi_ready = 1;
                rs_addr  = mi_addr;
                rs_len   = mi_len;
                rs_rw    = mi_rw;
                rs_idx   = 0;
                rs_busy  = 1;
            end
        end
    end

    // ---------------- behavioural run model ----------------
    logic [1:0]  cfg_mode, cfg_pat;
    logic [31:0] cfg_seed, cfg_base;
    logic [6:0]  cfg_burst;
    logic [15:0] cfg_count;
    logic [39:0] exp_cmd [$];
    logic [31:0] exp_w [$];
    logic [31:0] e_cnt, e_addr, e_data;
    logic        e_proto;

    function automatic logic [31:0] lfsr_next(input logic [31:0] c);
        return {c[30:0], c[31] ^ c[21] ^ c[1] ^ c[0]};
    endfunction

    function automatic logic [31:0] pat_at(input int i);
        logic [31:0] v;
        logic [31:0] a;
        a = cfg_base + 32'(i);
        case (cfg_pat)
            2'd0: begin
                v = (cfg_seed == 0) ? 32'd1 : cfg_seed;
                for (int j = 0; j < i; j++) v = lfsr_next(v);
            end
            2'd1:    v = a;
            2'd2:    v = cfg_seed;
            default: v = ~a;
        endcase
        return v;
    endfunction

    task automatic plan();
        int n;
        int tot;
        logic [31:0] a, rd;
        exp_cmd.delete();
        exp_w.delete();
        n   = int'(cfg_burst) + 1;
        tot = int'(cfg_count) * n;
        e_cnt = 0; e_addr = 0; e_data = 0;
        e_proto = (rlast_at >= 0) && (cfg_mode != 0) && (cfg_count != 0);
        if (cfg_mode != 2'd1) begin
            for (int k = 0; k < int'(cfg_count); k++)
                exp_cmd.push_back({cfg_base + 32'(k * n), cfg_burst, 1'b0});
            for (int i = 0; i < tot; i++) exp_w.push_back(pat_at(i));
        end
        if (cfg_mode != 2'd0) begin
            for (int k = 0; k < int'(cfg_count); k++)
                exp_cmd.push_back({cfg_base + 32'(k * n), cfg_burst, 1'b1});
            for (int i = 0; i < tot; i++) begin
                a  = cfg_base + 32'(i);
                rd = (cfg_mode == 2'd2) ? pat_at(i) : mem_rd(a);
                if (corrupt_en && a == corrupt_addr) rd = 32'hDEAD_BEEF;
                if (rd != pat_at(i)) begin
                    if (e_cnt == 0) begin
                        e_addr = a;
                        e_data = rd;
                    end
                    e_cnt++;
                end
            end
        end
    endtask

    // ---------------- per-cycle compare process ----------------
    logic        prev_valid = 0, prev_ack = 0;
    logic [39:0] prev_cmd = 0;

    initial begin
        logic [39:0] cur;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_valid = 0;
                prev_ack   = 0;
            end else begin
                cur = {mi_addr, mi_len, mi_rw};
                if (mi_valid && !prev_valid) begin
                    if (exp_cmd.size() == 0) chk("cmd_unexpected", 1, 0);
                    else                     chk("cmd", cur, exp_cmd[0]);
                end
                if (mi_valid && prev_valid) chk("cmd_stable", cur, prev_cmd);
                if (mi_valid && mi_ready && exp_cmd.size() > 0) void'(exp_cmd.pop_front());
                if (mi_wack) begin
                    if (exp_w.size() == 0) chk("wdata_unexpected", 1, 0);
                    else                   chk("wdata", mi_wdata, exp_w.pop_front());
                end
                if (wb_ack) chk("ack_consecutive", prev_ack, 0);
                else        chk("rdata_idle", wb_rdata, 0);
                prev_valid = mi_valid;
                prev_cmd   = cur;
                prev_ack   = wb_ack;
            end
        end
    end

    // ---------------- wishbone helpers ----------------
    task automatic wb_xfer(input logic [2:0] a, input logic we, input logic [31:0] d,
                           output logic [31:0] rd);
        int lat;
        @(negedge clk);
        wb_cyc = 1; wb_we = we; wb_addr = a; wb_wdata = d;
        lat = 0;
        for (int t = 1; t <= 4; t++) begin
            @(negedge clk);
            if (wb_ack) begin
                lat = t;
                break;
            end
        end
        rd = wb_rdata;
        wb_cyc = 0; wb_we = 0;
        chk("ack_latency", lat, 1);
    endtask

    task automatic wb_wr(input logic [2:0] a, input logic [31:0] d);
        logic [31:0] dummy;
        wb_xfer(a, 1'b1, d, dummy);
    endtask

    task automatic wb_rd(input logic [2:0] a, output logic [31:0] d);
        wb_xfer(a, 1'b0, 32'd0, d);
    endtask

    task automatic wait_idle();
        logic [31:0] d;
        d = 1;
        for (int t = 0; t < 3000 && d[0]; t++) wb_rd(3'd0, d);
        chk("run_finished", d[0], 0);
    endtask

    task automatic check_results();
        logic [31:0] d;
        wb_rd(3'd0, d);
        chk("csr", d, {24'd0, cfg_pat, cfg_mode, e_proto, (e_cnt != 0), 1'b1, 1'b0});
        wb_rd(3'd5, d); chk("err_cnt", d, e_cnt);
        wb_rd(3'd6, d); chk("err_addr", d, e_addr);
        wb_rd(3'd7, d); chk("err_data", d, e_data);
        chk("cmds_left", exp_cmd.size(), 0);
        chk("wdata_left", exp_w.size(), 0);
    endtask

    task automatic setup(input logic [1:0] mode, input logic [1:0] pat, input logic [31:0] seed,
                         input logic [31:0] base, input logic [6:0] burst, input logic [15:0] count);
        cfg_mode = mode; cfg_pat = pat; cfg_seed = seed;
        cfg_base = base; cfg_burst = burst; cfg_count = count;
        wb_wr(3'd1, base);
        wb_wr(3'd2, 32'(count));
        wb_wr(3'd3, 32'(burst));
        wb_wr(3'd4, seed);
        plan();
        rd_strobes = 0;
    endtask

    task automatic do_run(input logic [1:0] mode, input logic [1:0] pat, input logic [31:0] seed,
                          input logic [31:0] base, input logic [6:0] burst, input logic [15:0] count);
        setup(mode, pat, seed, base, burst, count);
        wb_wr(3'd0, {26'd0, pat, mode, 2'b01});
        wait_idle();
        check_results();
    endtask

    // LFSR words for SEED=1 worked out by hand from the feedback taps.
    logic [31:0] lit [8] = '{32'h1, 32'h3, 32'h6, 32'hD, 32'h1B, 32'h36, 32'h6D, 32'hDB};

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] d;
        int t;
        rst_n = 0; wb_cyc = 0; wb_we = 0; wb_addr = 0; wb_wdata = 0;
        repeat (3) @(negedge clk);
        rst_n = 1;
        chk("reset_valid", mi_valid, 0);
        chk("reset_addr", mi_addr, 0);
        for (int r = 0; r < 8; r++) begin
            wb_rd(3'(r), d);
            chk("reset_reg", d, 0);
        end

        // Write-only LFSR run.
        do_run(2'd0, 2'd0, 32'd1, 32'h100, 7'd3, 16'd2);
        for (int i = 0; i < 8; i++) chk("lfsr_word", mem_rd(32'h100 + 32'(i)), lit[i]);

        // Write+verify, clean then with one corrupted read.
        do_run(2'd2, 2'd1, 32'd0, 32'h20, 7'd15, 16'd4);
        corrupt_en = 1; corrupt_addr = 32'h25;
        do_run(2'd2, 2'd1, 32'd0, 32'h20, 7'd15, 16'd4);
        corrupt_en = 0;
        wb_rd(3'd5, d); chk("corrupt_cnt", d, 1);
        wb_rd(3'd6, d); chk("corrupt_addr", d, 32'h25);
        wb_rd(3'd7, d); chk("corrupt_data", d, 32'hDEAD_BEEF);

        // Stalled command, then abort.
        stall = 1;
        setup(2'd0, 2'd1, 32'd7, 32'h40, 7'd3, 16'd2);
        wb_wr(3'd0, {26'd0, 2'd1, 2'd0, 2'b01});
        for (t = 0; t < 20 && !mi_valid; t++) @(negedge clk);
        chk("stall_valid", mi_valid, 1);
        repeat (5) @(negedge clk);
        wb_wr(3'd0, 32'h2);
        chk("abort_valid", mi_valid, 0);
        exp_cmd.delete(); exp_w.delete();
        stall = 0;
        wb_rd(3'd0, d); chk("abort_csr", d, 32'h40);
        repeat (5) @(negedge clk);

        // Early rlast inside a 4-word verify burst.
        for (int i = 0; i < 4; i++) mem[32'h200 + 32'(i)] = 32'h1234_5678;
        rlast_at = 2;
        do_run(2'd1, 2'd2, 32'h1234_5678, 32'h200, 7'd3, 16'd1);
        rlast_at = -1;
        chk("rd_strobes", rd_strobes, 4);

        // Zero bursts.
        do_run(2'd0, 2'd0, 32'd5, 32'h300, 7'd3, 16'd0);

        // Start and register writes while busy are ignored.
        setup(2'd0, 2'd2, 32'hCAFE_F00D, 32'h400, 7'd7, 16'd3);
        wb_wr(3'd0, {26'd0, 2'd2, 2'd0, 2'b01});
        wb_wr(3'd1, 32'h999);
        wb_wr(3'd0, {26'd0, 2'd3, 2'd1, 2'b01});
        wait_idle();
        check_results();
        wb_rd(3'd1, d); chk("base_kept", d, 32'h400);

        // Randomised runs.
        for (int it = 0; it < 10; it++) begin
            do_run(2'($urandom_range(0, 2)), 2'($urandom_range(0, 3)),
                   ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom,
                   $urandom, 7'($urandom_range(0, 7)), 16'($urandom_range(1, 4)));
        end

        // Reset in the middle of a write burst.
        setup(2'd0, 2'd0, 32'h55, 32'h600, 7'd7, 16'd4);
        wb_wr(3'd0, 32'h1);
        for (t = 0; t < 200 && !mi_wack; t++) @(negedge clk);
        chk("midrun_wack", mi_wack, 1);
        @(negedge clk);
        rst_n = 0;
        exp_cmd.delete(); exp_w.delete();
        @(negedge clk);
        chk("reset_midrun_valid", mi_valid, 0);
        @(negedge clk);
        rst_n = 1;
        for (int r = 0; r < 8; r++) begin
            wb_rd(3'(r), d);
            chk("reset_midrun_reg", d, 0);
        end
        repeat (10) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
